// File: rtl/norm_shift_unit_if.sv
// Handshake and data bundle for the left-normalizer: request side (master)
// drives the operand and start, the normalizer (slave) returns the result.
interface norm_shift_unit_if;
  logic        start;
  logic [31:0] a;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic [31:0] c;
  logic [5:0]  cnt;
  logic        zero;

  modport master (
    output start, a, signed_mode,
    input  busy, done, c, cnt, zero
  );

  modport slave (
    input  start, a, signed_mode,
    output busy, done, c, cnt, zero
  );
endinterface

// File: rtl/norm_shift_unit.sv
// Iterative left-normalizer: shifts the latched operand one bit per cycle until
// it is normalized (unsigned: MSB set, signed: MSB differs from bit 30).
module norm_shift_unit (
  input  logic               clk,
  input  logic               rst,
  norm_shift_unit_if.slave   bus
);
  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   r;
  logic                sm;
  logic [DATA_W-1:0]   c_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                zero_q;
  logic                r_zero;
  logic                r_norm;
  logic                busy_d;
  logic                done_d;

  function automatic logic is_normalized(input logic [DATA_W-1:0] v, input logic smode);
    is_normalized = smode ? (v[DATA_W-1] ^ v[DATA_W-2]) : v[DATA_W-1];
  endfunction

  assign r_zero = (r == '0);
  assign r_norm = is_normalized(r, sm);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = bus.start ? SHIFT : IDLE;
      SHIFT:      if (r_zero || r_norm) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Status flags decode only the state register, so no input reaches an output.
  always_comb begin
    busy_d = (state == SHIFT);
    done_d = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r      <= '0;
      sm     <= 1'b0;
      c_q    <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            r      <= bus.a;
            sm     <= bus.signed_mode;
            cnt_q  <= '0;
            zero_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (r_zero) begin
            zero_q <= 1'b1;
            cnt_q  <= CNT_W'(DATA_W);
            c_q    <= '0;
          end else if (r_norm) begin
            c_q    <= r;
          end else begin
            r      <= {r[DATA_W-2:0], 1'b0};
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_d;
  assign bus.done = done_d;
  assign bus.c    = c_q;
  assign bus.cnt  = cnt_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_norm_shift_unit.sv
// Bench for norm_shift_unit: cycle-level behavioural model plus directed and
// randomized operations, compared against the DUT on every cycle.
module tb_norm_shift_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  norm_shift_unit_if bus();
  norm_shift_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Result from the definition: unsigned = leading zeros, signed = redundant sign bits.
  function automatic void ref_norm(input logic [31:0] v, input bit smode,
                                   output logic [31:0] rc, output int rcnt,
                                   output bit rz, output int rk);
    rz = (v == 32'h0);
    rk = 0;
    rcnt = 0;
    rc = 32'h0;
    if (rz) begin
      rcnt = 32;
      return;
    end
    if (!smode) begin
      for (int i = 31; i >= 0; i--) begin
        if (v[i]) begin
          rk = 31 - i;
          break;
        end
      end
    end else begin
      for (int i = 30; i >= 0; i--) begin
        if (v[i] != v[31]) break;
        rk++;
      end
    end
    rcnt = rk;
    rc = v << rk;
  endfunction

  // Model: an accepted op is busy for k+1 cycles, then a one-cycle done.
  int          m_left = 0;
  int          m_k    = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_c    = 32'h0;
  int          m_cnt  = 0;
  bit          m_zero = 1'b0;
  logic [31:0] p_c;
  int          p_cnt;
  bit          p_zero;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_c = 32'h0; m_cnt = 0; m_zero = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_c = p_c; m_cnt = p_cnt; m_zero = p_zero;
      end else begin
        m_cnt = m_k + 1 - m_left;
      end
    end else begin
      m_done = 1'b0;
      if (bus.start) begin
        ref_norm(bus.a, bus.signed_mode, p_c, p_cnt, p_zero, m_k);
        m_left = m_k + 1;
        m_cnt  = 0;
        m_zero = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(bus.busy), 32'(m_left > 0));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("c",    bus.c,         m_c);
      chk("cnt",  32'(bus.cnt),  32'(m_cnt));
      chk("zero", 32'(bus.zero), 32'(m_zero));
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle with start low.
  task automatic run_op(input logic [31:0] va, input bit vs, input int exp_lat,
                        input bit hold, output int lat);
    bus.start = 1'b1;
    bus.a = va;
    bus.signed_mode = vs;
    lat = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = cyc;
        bus.start = 1'b0;
        break;
      end
      bus.start = hold;
      bus.a = $urandom;
      if (hold) bus.signed_mode = 1'($urandom_range(0, 1));
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none expected=pulse within 40 cycles");
      bus.start = 1'b0;
    end else if (exp_lat > 0) begin
      chk("latency", 32'(lat), 32'(exp_lat));
    end
  endtask

  task automatic dir_op(input logic [31:0] va, input bit vs, input int exp_lat,
                        input logic [31:0] ec, input int ecnt, input bit ez, input bit hold);
    int lat;
    run_op(va, vs, exp_lat, hold, lat);
    chk("dir_c",    bus.c,         ec);
    chk("dir_cnt",  32'(bus.cnt),  32'(ecnt));
    chk("dir_zero", 32'(bus.zero), 32'(ez));
  endtask

  logic [31:0] t_c;
  int          t_cnt;
  bit          t_z;
  int          t_k;
  int          lat_r;
  logic [31:0] rv;

  initial begin
    bus.start = 1'b0;
    bus.a = 32'h0;
    bus.signed_mode = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_c",    bus.c,         32'h0);
    chk("rst_cnt",  32'(bus.cnt),  32'h0);
    chk("rst_zero", 32'(bus.zero), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    ref_norm(32'h00012345, 1'b0, t_c, t_cnt, t_z, t_k);
    chk("model_u_c", t_c, 32'h91A28000);
    chk("model_u_cnt", 32'(t_cnt), 32'd15);
    ref_norm(32'hFFFFFFFF, 1'b1, t_c, t_cnt, t_z, t_k);
    chk("model_m1_c", t_c, 32'h80000000);
    chk("model_m1_cnt", 32'(t_cnt), 32'd31);
    ref_norm(32'h00000000, 1'b1, t_c, t_cnt, t_z, t_k);
    chk("model_z_cnt", 32'(t_cnt), 32'd32);

    @(negedge clk);
    dir_op(32'h80000000, 1'b0, 2,  32'h80000000, 0,  1'b0, 1'b0);
    @(negedge clk);
    dir_op(32'h00012345, 1'b0, 17, 32'h91A28000, 15, 1'b0, 1'b0);
    dir_op(32'h40000000, 1'b0, 3,  32'h80000000, 1,  1'b0, 1'b0);
    @(negedge clk);
    dir_op(32'hFFFFF000, 1'b1, 21, 32'h80000000, 19, 1'b0, 1'b1);
    @(negedge clk);
    dir_op(32'h00000003, 1'b1, 31, 32'h60000000, 29, 1'b0, 1'b0);
    @(negedge clk);
    dir_op(32'h00000000, 1'b0, 2,  32'h00000000, 32, 1'b1, 1'b0);
    dir_op(32'h00000000, 1'b1, 2,  32'h00000000, 32, 1'b1, 1'b0);
    dir_op(32'hFFFFFFFF, 1'b1, 33, 32'h80000000, 31, 1'b0, 1'b0);
    dir_op(32'h00000001, 1'b0, 33, 32'h80000000, 31, 1'b0, 1'b0);

    // Reset during cycle 5 of a long op; start coincident with rst is ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h00000001; bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_done", 32'(bus.done), 32'h0);
    chk("mid_rst_c",    bus.c,         32'h0);
    chk("mid_rst_cnt",  32'(bus.cnt),  32'h0);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'h0);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 5))
        0: rv = $urandom;
        1: rv = $urandom >> $urandom_range(0, 31);
        2: rv = ~($urandom >> $urandom_range(0, 31));
        3: rv = 32'h0;
        4: rv = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h00000001;
        default: rv = 32'h1 << $urandom_range(0, 31);
      endcase
      run_op(rv, 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)), lat_r);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
